// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg: shared widths, reset divisor and channel-index width helper
package clk_div_multi_pkg;
  localparam int CNT_W_DEF = 26;
  localparam int DEFAULT_DIV_DEF = 30000000;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: run control, divisor load port and divided outputs
interface clk_div_multi_if import clk_div_multi_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF
) ();
  localparam int CH_W = ch_w(NUM_CH);
  logic [NUM_CH-1:0] en;
  logic sync_all;
  logic load_valid;
  logic [CH_W-1:0] load_ch;
  logic [CNT_W-1:0] load_div;
  logic load_ready;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  modport master (output en, sync_all, load_valid, load_ch, load_div,
                  input load_ready, clk_out, tick);
  modport slave (input en, sync_all, load_valid, load_ch, load_div,
                 output load_ready, clk_out, tick);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with glitch-free pending divisor apply
module clk_div_chan import clk_div_multi_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  input  logic sync,
  input  logic load_strobe,
  input  logic [CNT_W-1:0] load_div,
  output logic clk_out,
  output logic tick,
  output logic pend_flag
);
  logic [CNT_W-1:0] cnt, div_act, div_pend;
  logic term;
  assign term = cnt == div_act - CNT_W'(1);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
      div_act <= CNT_W'(DEFAULT_DIV);
      div_pend <= '0;
      pend_flag <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else if (sync) begin
      cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
      pend_flag <= 1'b0;
      div_act <= load_strobe ? load_div : pend_flag ? div_pend : div_act;
    end else begin
      if (load_strobe) begin
        div_pend <= load_div;
        pend_flag <= 1'b1;
      end
      // a stopped or paused channel has no terminal count to wait for
      if (pend_flag && (div_act == '0 || !en)) begin
        div_act <= div_pend;
        pend_flag <= 1'b0;
        cnt <= '0;
        tick <= 1'b0;
      end else if (div_act == '0) begin
        cnt <= '0;
        clk_out <= 1'b0;
        tick <= 1'b0;
      end else if (!en) begin
        tick <= 1'b0;
      end else if (term) begin
        cnt <= '0;
        clk_out <= ~clk_out;
        tick <= 1'b1;
        if (pend_flag) begin
          div_act <= div_pend;
          pend_flag <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable 50%-duty clock dividers with tick strobes
module clk_div_multi import clk_div_multi_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic clk_in,
  input logic rst,
  clk_div_multi_if.slave bus
);
  localparam int CH_W = ch_w(NUM_CH);
  logic [NUM_CH-1:0] pend, clk_o, tick_o;
  logic [2**CH_W-1:0] pend_ext;
  assign pend_ext = (2**CH_W)'(pend);
  // zero-extended flags keep out-of-range indices from reading past pend
  assign bus.load_ready = ({1'b0, bus.load_ch} < (CH_W+1)'(NUM_CH)) && !pend_ext[bus.load_ch];
  assign bus.clk_out = clk_o;
  assign bus.tick = tick_o;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk_in(clk_in),
      .rst(rst),
      .en(bus.en[c]),
      .sync(bus.sync_all),
      .load_strobe(bus.load_valid && bus.load_ready && (bus.load_ch == CH_W'(c))),
      .load_div(bus.load_div),
      .clk_out(clk_o[c]),
      .tick(tick_o[c]),
      .pend_flag(pend[c])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed cycle-accurate checks of the multi-channel divider
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  clk_div_multi_if #(.NUM_CH(2), .CNT_W(8)) bus ();
  clk_div_multi_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();
  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk_in(clk), .rst(rst), .bus(bus));
  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
    .clk_in(clk), .rst(rst), .bus(bus3));
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] ch, input logic [7:0] div);
    bus.load_valid = 1'b1;
    bus.load_ch = ch[0];
    bus.load_div = div;
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 2'b00; bus.sync_all = 1'b0; bus.load_valid = 1'b0; bus.load_ch = 1'b0; bus.load_div = '0;
    bus3.en = 3'b000; bus3.sync_all = 1'b0; bus3.load_valid = 1'b0; bus3.load_ch = 2'd0; bus3.load_div = '0;
    step(3);
    chk("rst_clk", 8'(bus.clk_out), 8'h0);
    chk("rst_tick", 8'(bus.tick), 8'h0);
    chk("rst_ready", 8'(bus.load_ready), 8'h1);
    rst = 1'b0;
    bus.en = 2'b11;
    for (int i = 1; i <= 3; i++) begin step(); chk("tick_early", 8'(bus.tick), 8'h0); end
    step();
    chk("tick_e4", 8'(bus.tick), 8'h3);
    chk("clk_e4", 8'(bus.clk_out), 8'h3);
    for (int i = 5; i <= 7; i++) begin step(); chk("clk_hi", 8'(bus.clk_out), 8'h3); end
    step();
    chk("tick_e8", 8'(bus.tick), 8'h3);
    chk("clk_e8", 8'(bus.clk_out), 8'h0);
    step();
    load(0, 8'd2);
    chk("ready_free", 8'(bus.load_ready), 8'h1);
    step();
    bus.load_valid = 1'b0;
    chk("ready_pend", 8'(bus.load_ready), 8'h0);
    step();
    chk("ready_e11", 8'(bus.load_ready), 8'h0);
    chk("tick_e11", 8'(bus.tick), 8'h0);
    step();
    chk("tick_apply", 8'(bus.tick), 8'h3);
    chk("clk_apply", 8'(bus.clk_out), 8'h3);
    chk("ready_apply", 8'(bus.load_ready), 8'h1);
    step(2);
    chk("tick_e14", 8'(bus.tick), 8'h1);
    chk("clk_e14", 8'(bus.clk_out), 8'h2);
    step();
    chk("tick_e15", 8'(bus.tick), 8'h0);
    step();
    chk("tick_e16", 8'(bus.tick), 8'h3);
    chk("clk_e16", 8'(bus.clk_out), 8'h1);
    load(0, 8'd3);
    step();
    chk("ready_e17", 8'(bus.load_ready), 8'h0);
    step();
    chk("ready_e18", 8'(bus.load_ready), 8'h1);
    chk("tick_e18", 8'(bus.tick), 8'h1);
    step();
    bus.load_valid = 1'b0;
    chk("ready_e19", 8'(bus.load_ready), 8'h0);
    step();
    chk("ready_e20", 8'(bus.load_ready), 8'h0);
    chk("tick_e20", 8'(bus.tick), 8'h2);
    step();
    chk("ready_e21", 8'(bus.load_ready), 8'h1);
    chk("tick_e21", 8'(bus.tick), 8'h1);
    chk("clk_e21", 8'(bus.clk_out), 8'h3);
    load(1, 8'd0);
    step();
    bus.load_valid = 1'b0;
    step(2);
    chk("tick_e24", 8'(bus.tick), 8'h3);
    chk("clk_e24", 8'(bus.clk_out), 8'h0);
    for (int i = 25; i <= 28; i++) begin
      step();
      chk("stop_tick1", 8'(bus.tick[1]), 8'h0);
      chk("stop_clk1", 8'(bus.clk_out[1]), 8'h0);
    end
    load(1, 8'd1);
    step();
    bus.load_valid = 1'b0;
    chk("ready_ch1_pend", 8'(bus.load_ready), 8'h0);
    step();
    chk("imm_clk1", 8'(bus.clk_out[1]), 8'h0);
    chk("imm_tick1", 8'(bus.tick[1]), 8'h0);
    chk("imm_ready", 8'(bus.load_ready), 8'h1);
    step();
    chk("div1_tick_e31", 8'(bus.tick[1]), 8'h1);
    chk("div1_clk_e31", 8'(bus.clk_out[1]), 8'h1);
    step();
    chk("div1_tick_e32", 8'(bus.tick[1]), 8'h1);
    chk("div1_clk_e32", 8'(bus.clk_out[1]), 8'h0);
    bus.en = 2'b10;
    for (int i = 33; i <= 37; i++) begin
      step();
      chk("hold_tick0", 8'(bus.tick[0]), 8'h0);
      chk("hold_clk0", 8'(bus.clk_out[0]), 8'h0);
    end
    bus.en = 2'b11;
    step();
    chk("resume_tick0", 8'(bus.tick[0]), 8'h1);
    chk("resume_clk0", 8'(bus.clk_out[0]), 8'h1);
    bus.sync_all = 1'b1;
    load(0, 8'd2);
    step();
    bus.sync_all = 1'b0;
    bus.load_valid = 1'b0;
    chk("sync_clk", 8'(bus.clk_out), 8'h0);
    chk("sync_tick", 8'(bus.tick), 8'h0);
    chk("sync_ready", 8'(bus.load_ready), 8'h1);
    step();
    chk("sync_tick_e40", 8'(bus.tick), 8'h2);
    chk("sync_clk_e40", 8'(bus.clk_out), 8'h2);
    step();
    chk("sync_tick_e41", 8'(bus.tick), 8'h3);
    chk("sync_clk_e41", 8'(bus.clk_out), 8'h1);
    load(0, 8'd7);
    step();
    bus.load_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_clk", 8'(bus.clk_out), 8'h0);
    chk("rst2_tick", 8'(bus.tick), 8'h0);
    chk("rst2_ready0", 8'(bus.load_ready), 8'h1);
    bus.load_ch = 1'b1;
    #1;
    chk("rst2_ready1", 8'(bus.load_ready), 8'h1);
    step(3);
    chk("rst2_tick_e3", 8'(bus.tick), 8'h0);
    step();
    chk("rst2_tick_e4", 8'(bus.tick), 8'h3);
    step(3);
    chk("rst2_tick_e7", 8'(bus.tick), 8'h0);
    step();
    chk("rst2_tick_e8", 8'(bus.tick), 8'h3);
    bus3.load_ch = 2'd2;
    #1;
    chk("ch3_ready_valid", 8'(bus3.load_ready), 8'h1);
    bus3.load_ch = 2'd3;
    #1;
    chk("ch3_ready_oob", 8'(bus3.load_ready), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
